iis_sync_fifo: RTL and testbench

Single-clock, parametrised sample FIFO for the IIS audio path, placed between the IIS receiver/transmitter shift logic and the APB-side sample registers wherever both run from the same clock. Generalises the existing IIS sample buffering in four ways:
- configurable width and depth;
- selectable standard or first-word-fall-through (FWFT) read mode;
- a live fill level with programmable almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags cleared by a synchronous flush.

---
 rtl/iis_sync_fifo.sv | 119 +++++++++++
 tb/tb_iis_sync_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/iis_sync_fifo.sv
// Single-clock sample FIFO for the IIS audio path: configurable width/depth,
// standard or first-word-fall-through read, live fill level, sticky error flags.
module iis_sync_fifo #(
  parameter int data_width = 16,
  parameter int addr_width = 3,
  parameter int data_depth = 8,
  parameter int fwft       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [data_width-1:0] din,
  input  logic                  rd_en,
  output logic [data_width-1:0] dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  input  logic [addr_width:0]   almost_full_thr,
  input  logic [addr_width:0]   almost_empty_thr,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_width:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int lw = addr_width + 1;

  logic [data_width-1:0] mem_q [data_depth];
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [lw-1:0]         level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wa, ra;

  // Flags decode from the registered level, so acceptance always sees pre-edge state.
  assign full         = (level_q == lw'(data_depth));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= almost_full_thr);
  assign almost_empty = (level_q <= almost_empty_thr);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wa = wr_en & ~full;
  assign ra = rd_en & ((fwft != 0) ? valid : ~empty);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q | (wr_en & full);
    underflow_d = underflow_q | (rd_en & empty);
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wa) wr_ptr_d = wr_ptr_q + addr_width'(1);
      if (ra) rd_ptr_d = rd_ptr_q + addr_width'(1);
      case ({wa, ra})
        2'b10:   level_d = level_q + lw'(1);
        2'b01:   level_d = level_q - lw'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: the sample array has no reset; level/pointers guard every read, so stale contents are never exposed.
  always_ff @(posedge clk) begin
    if (wa && !flush) mem_q[wr_ptr_q] <= din;
  end

  if (fwft != 0) begin : g_fwft
    assign valid = ~empty;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  end else begin : g_std
    logic [data_width-1:0] dout_q;
    logic                  valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= ra;
        if (ra) dout_q <= mem_q[rd_ptr_q];
      end
    end

    assign valid = valid_q;
    assign dout  = dout_q;
  end

endmodule

// File: tb/tb_iis_sync_fifo.sv
// Scoreboard bench for iis_sync_fifo: one standard-mode and one FWFT instance share
// stimulus; a queue-based model predicts contents, flags and read data.
module tb_iis_sync_fifo;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst, flush, wr_en, rd_en;
  logic [DW-1:0] din;
  logic [AW:0]   af_thr, ae_thr;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic          f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [AW:0]   s_level, f_level;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model[$];
  logic [DW-1:0] exp_std[$];
  logic [DW-1:0] exp_fw[$];
  bit            ovf_m, unf_m, std_valid_m;
  logic [DW-1:0] last_std;

  always #5 clk = ~clk;

  iis_sync_fifo #(.data_width(DW), .addr_width(AW), .data_depth(DEPTH), .fwft(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .valid(s_valid), .full(s_full), .empty(s_empty),
    .almost_full_thr(af_thr), .almost_empty_thr(ae_thr),
    .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
    .overflow(s_ovf), .underflow(s_unf)
  );

  iis_sync_fifo #(.data_width(DW), .addr_width(AW), .data_depth(DEPTH), .fwft(1)) u_fw (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full_thr(af_thr), .almost_empty_thr(ae_thr),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard-mode monitor: every valid pulse must match the oldest accepted read.
  always @(negedge clk) begin
    if (s_valid === 1'b1) begin
      if (exp_std.size() == 0) check("std_spurious_valid", 32'd1, 32'd0);
      else check("std_read_data", 32'(s_dout), 32'(exp_std.pop_front()));
    end
  end

  // FWFT monitor: the head word is consumed when rd_en meets valid.
  always @(negedge clk) begin
    if (f_valid === 1'b1 && rd_en && !flush && !rst) begin
      if (exp_fw.size() == 0) check("fwft_spurious_read", 32'd1, 32'd0);
      else check("fwft_read_data", 32'(f_dout), 32'(exp_fw.pop_front()));
    end
  end

  task automatic check_state();
    int            lvl;
    logic [5:0]    flags_m;
    logic [DW-1:0] head;
    lvl     = model.size();
    flags_m = {lvl == DEPTH, lvl == 0, lvl >= int'(af_thr), lvl <= int'(ae_thr), ovf_m, unf_m};
    head    = (lvl == 0) ? '0 : model[0];
    check("level_std", 32'(s_level), 32'(lvl));
    check("level_fwft", 32'(f_level), 32'(lvl));
    check("flags_std", 32'({s_full, s_empty, s_af, s_ae, s_ovf, s_unf}), 32'(flags_m));
    check("flags_fwft", 32'({f_full, f_empty, f_af, f_ae, f_ovf, f_unf}), 32'(flags_m));
    check("std_valid", 32'(s_valid), 32'(std_valid_m));
    check("std_dout_hold", 32'(s_dout), 32'(last_std));
    check("fwft_valid", 32'(f_valid), 32'(lvl != 0));
    check("fwft_head", 32'(f_dout), 32'(head));
  endtask

  // One clock of stimulus; the model applies the FIFO rules to pre-edge occupancy.
  task automatic step(input bit wr, input bit rd, input logic [DW-1:0] d, input bit fl);
    bit            fm, em;
    logic [DW-1:0] w;
    #1;
    wr_en = wr; rd_en = rd; din = d; flush = fl;
    fm = (model.size() == DEPTH);
    em = (model.size() == 0);
    std_valid_m = 1'b0;
    if (fl) begin
      model.delete();
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end else begin
      if (wr && fm) ovf_m = 1'b1;
      if (rd && em) unf_m = 1'b1;
      if (rd && !em) begin
        w = model.pop_front();
        exp_std.push_back(w);
        exp_fw.push_back(w);
        last_std    = w;
        std_valid_m = 1'b1;
      end
      if (wr && !fm) model.push_back(d);
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    model.delete();
    exp_std.delete();
    exp_fw.delete();
    ovf_m = 1'b0; unf_m = 1'b0; std_valid_m = 1'b0;
    last_std = '0;
    check_state();
    @(posedge clk);
    #1;
    check_state();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    af_thr = 4'd6; ae_thr = 4'd2;
    #1;
    apply_reset();

    // Fill then drain; thresholds 6/2 are exercised at every level on the way.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, 1'b0);

    // Overflow with a marker word, drain, underflow, flush clears.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(16'h0100 + i), 1'b0);
    step(1'b1, 1'b0, 16'hDEAD, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);

    // Simultaneous access at full and at empty.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(16'h0200 + i), 1'b0);
    step(1'b1, 1'b1, 16'hBEEF, 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, '0, 1'b0);
    step(1'b1, 1'b1, 16'h0CAB, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);

    // Wrap-around at constant level 3.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(16'h0300 + i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'(16'h0400 + i), 1'b0);

    // FWFT single word into an empty FIFO, then acknowledged.
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 16'h00AA, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);

    // Reset mid-stream with a read in flight; almost_full_thr=0 checks that reset corner.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(16'h0500 + i), 1'b0);
    step(1'b1, 1'b1, 16'h0555, 1'b0);
    af_thr = 4'd0;
    apply_reset();
    af_thr = 4'd6;

    // Randomized traffic with phases of write-heavy, read-heavy and balanced load.
    for (int i = 0; i < 400; i++) begin
      int pw, pr;
      case ((i / 50) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        default: begin pw = 55; pr = 55; end
      endcase
      if (i % 60 == 0) begin
        af_thr = 4'($urandom_range(0, DEPTH));
        ae_thr = 4'($urandom_range(0, DEPTH));
      end
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
           DW'($urandom), $urandom_range(0, 59) == 0);
    end

    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    check("std_pending_reads", 32'(exp_std.size()), 32'd0);
    check("fwft_pending_reads", 32'(exp_fw.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
